muldiv_hilo_unit: RTL and testbench
===================================

// Module: muldiv_hilo_unit
// PURPOSE
//  Multi-cycle signed multiply/divide unit with HI/LO result registers.
//  Sits directly downstream of the ALU control decode and consumes its 4-bit ALU control code.
//  Acts on the MUL (4'b1011) and DIV (4'b1100) codes and ignores every other code.
//  The CPU holds its PC while busy is high; mfhi/mflo read hi/lo.
// PARAMETERS
//  XLEN  32  operand and HI/LO width; iteration count equals XLEN
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  start      in   1     request; sampled only when busy==0
//  alu_ctr    in   4     ALU control code; 4'b1011=mul, 4'b1100=div
//  op_a       in   XLEN  rs: multiplicand or dividend
//  op_b       in   XLEN  rt: multiplier or divisor
//  busy       out  1     operation in flight; pipeline stall request
//  done       out  1     one-cycle pulse; hi/lo hold the new result
//  hi         out  XLEN  mul: product[2*XLEN-1:XLEN]; div: remainder
//  lo         out  XLEN  mul: product[XLEN-1:0]; div: quotient
// BEHAVIOUR
//  - Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, iteration counter=0.
//  - States: IDLE, MUL, DIV, DONE. DONE lasts exactly one cycle, then returns to IDLE.
//  - Accept: in IDLE or DONE, when start=1 and alu_ctr is MUL or DIV, the unit captures operands at edge E0.
//    - It stores |op_a|, |op_b| and the result signs.
//    - busy=1 from E0.
//    - Any other alu_ctr with start=1 is ignored and causes no state change.
//  - start while busy=1: ignored. Operands are not re-sampled.
//  - MUL: radix-2 shift-add over magnitudes, one bit per cycle at edges E1..E32.
//    - At E33: hi:lo <= 64-bit two's-complement product, sign = a^b.
//    - At E33: done=1 and busy=0.
//  - DIV: restoring division over magnitudes, one bit per cycle at E1..E32. Results are written at E33.
//    - Quotient sign = a^b. Remainder sign = sign of op_a.
//  - DIV with op_b==0: no iterations. At E1: lo=32'hFFFFFFFF, hi=op_a, done=1, busy=0.
//  - DIV INT_MIN / -1: lo=32'h80000000, hi=0 (magnitude wrap). No trap.
//  - hi/lo change only on the done edge and otherwise hold.
//  - done is low whenever busy is high.
//  - A new start is accepted in the DONE cycle. Back-to-back operations lose no cycle.
//  - Reset mid-operation: immediately returns to IDLE, hi/lo=0, and no done pulse follows.
// CONFIGURATION
//  - Macro MULDIV_UNSIGNED_EN.
//  - Defined: adds input port is_unsigned (1 bit), sampled with start.
//    - When is_unsigned=1, operands are taken as unsigned and sign correction is skipped (multu/divu).
//    - Divide-by-zero gives lo=all ones, hi=op_a.
//  - Undefined: no is_unsigned port; all operations are signed exactly as above.
// STRUCTURE
//  - Package muldiv_pkg holds:
//    - XLEN default;
//    - ALUCTR_MUL=4'b1011, ALUCTR_DIV=4'b1100;
//    - state encoding localparams IDLE/MUL/DIV/DONE.
//  - Sub-module muldiv_iter_core is the shared shift/add-subtract datapath.
//    - It holds the accumulator, shift register and counter, and runs one iteration per cycle.
//  - The top level keeps the FSM, sign capture/correction, the divide-by-zero path and the HI/LO registers.
// TESTING
//  - mul 7 * -3, start at E0: busy 1 for 33 cycles; done at E33; hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
//  - div -7 / 2: lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1), done at E33.
//  - div 5 / 0: done at E1; lo=32'hFFFFFFFF, hi=32'h00000005; busy high for one cycle only.
//  - div 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
//  - mul 32'h80000000 * 32'h80000000: hi=32'h40000000, lo=0.
//  - start with alu_ctr=4'b0010: no busy, no done, hi/lo unchanged.
//  - Second start (mul 2*2) at E5 during a div: ignored; div result intact.
//  - Second start in the DONE cycle: accepted; its done follows 33 cycles later.
//  - rst_n low at E10 of a mul: busy=0, hi=lo=0 at once; no done pulse through E40.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide HI/LO unit: ALU control codes,
// default operand width and the controller state encoding.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALUCTR_MUL = 4'b1011;
    localparam logic [3:0] ALUCTR_DIV = 4'b1100;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_MUL  = MUL,
        ST_DIV  = DIV,
        ST_DONE = DONE
    } state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative magnitude datapath: radix-2 shift-add multiply or restoring divide,
// one bit per cycle, with accumulator, shift register and iteration counter.
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            div_sel,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] sr,
    output logic            fin
);

    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] sr_q, sr_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // Mul: sr holds the multiplier, low product bits shift in from the top.
    // Div: sr holds the dividend, quotient bits shift in from the bottom.
    always_comb begin
        acc_d   = acc_q;
        sr_d    = sr_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        add_sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        shifted = {acc_q, sr_q[XLEN-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd_q};

        if (load) begin
            acc_d  = '0;
            cnt_d  = '0;
            sr_d   = div_sel ? a_mag : b_mag;
            opnd_d = div_sel ? b_mag : a_mag;
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (div_sel) begin
                if (!diff[XLEN+1]) begin
                    acc_d = diff[XLEN-1:0];
                    sr_d  = {sr_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = shifted[XLEN-1:0];
                    sr_d  = {sr_q[XLEN-2:0], 1'b0};
                end
            end else begin
                acc_d = add_sum[XLEN:1];
                sr_d  = {add_sum[0], sr_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        sr_q   <= sr_d;
        opnd_q <= opnd_d;
    end

    assign acc = acc_q;
    assign sr  = sr_q;
    assign fin = (cnt_q == CW'(XLEN));

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle signed multiply/divide unit with HI/LO result registers.
// Optional macro MULDIV_UNSIGNED_EN adds an is_unsigned port for multu/divu.
module muldiv_hilo_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      alu_ctr,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
`ifdef MULDIV_UNSIGNED_EN
    input  logic            is_unsigned,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e            state_q, state_d;
    logic              qsign_q, qsign_d;
    logic              rsign_q, rsign_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              uns;
    logic              sa, sb;
    logic              is_mul, is_div, accept;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic              load, step, div_sel;
    logic [XLEN-1:0]   core_acc, core_sr;
    logic              core_fin;

`ifdef MULDIV_UNSIGNED_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    muldiv_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .step    (step),
        .div_sel (div_sel),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .acc     (core_acc),
        .sr      (core_sr),
        .fin     (core_fin)
    );

    // Magnitude of INT_MIN wraps to itself, which is exactly the unsigned 2^(XLEN-1).
    always_comb begin
        sa     = op_a[XLEN-1] & ~uns;
        sb     = op_b[XLEN-1] & ~uns;
        a_mag  = cond_neg(op_a, sa);
        b_mag  = cond_neg(op_b, sb);
        is_mul = (alu_ctr == ALUCTR_MUL);
        is_div = (alu_ctr == ALUCTR_DIV);
        accept = start && (is_mul || is_div) &&
                 ((state_q == ST_IDLE) || (state_q == ST_DONE));
        prod   = cond_neg_wide({core_acc, core_sr}, qsign_q);
    end

    always_comb begin
        state_d = state_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;
        step    = 1'b0;
        div_sel = (state_q == ST_DIV);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    load    = 1'b1;
                    div_sel = is_div;
                    state_d = is_div ? ST_DIV : ST_MUL;
                    qsign_d = sa ^ sb;
                    rsign_d = sa;
                    dz_d    = is_div && (op_b == '0);
                end
            end
            ST_MUL: begin
                if (core_fin) begin
                    hi_d    = prod[2*XLEN-1:XLEN];
                    lo_d    = prod[XLEN-1:0];
                    state_d = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DIV: begin
                // Divide-by-zero skips iteration; the core still holds |op_a| in sr.
                if (dz_q) begin
                    lo_d    = '1;
                    hi_d    = cond_neg(core_sr, rsign_q);
                    state_d = ST_DONE;
                end else if (core_fin) begin
                    lo_d    = cond_neg(core_sr, qsign_q);
                    hi_d    = cond_neg(core_acc, rsign_q);
                    state_d = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: signed mul/div, divide-by-zero, overflow
// corners, ignored starts, back-to-back issue and mid-operation reset.
module tb_muldiv_hilo_unit;

    localparam logic [3:0] C_MUL = 4'b1011;
    localparam logic [3:0] C_DIV = 4'b1100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_ctr;
    logic [31:0] op_a, op_b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc, bcnt, seen_b, seen_d;

    always #5 clk = ~clk;

    muldiv_hilo_unit #(
        .XLEN (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .alu_ctr (alu_ctr),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; the request is captured at the next edge (E0).
    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        alu_ctr = c;
        op_a    = a;
        op_b    = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        alu_ctr = 4'b0000;
    endtask

    // Counts edges after the reference edge until done is seen; 60 means timeout.
    task automatic wait_done(output int c, output int bc);
        c  = 0;
        bc = int'(busy);
        while (c < 60) begin
            @(posedge clk);
            #1;
            c++;
            if (done) break;
            bc += int'(busy);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        alu_ctr = 4'b0000;
        op_a    = '0;
        op_b    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);

        // mul 7 * -3
        start_op(C_MUL, 32'd7, 32'hFFFF_FFFD);
        check_val("mul_busy_e0", busy, 1);
        wait_done(cyc, bcnt);
        check_val("mul_done_cyc", cyc, 33);
        check_val("mul_busy_cycles", bcnt, 33);
        check_val("mul_busy_at_done", busy, 0);
        check_val("mul_hi", hi, 32'hFFFF_FFFF);
        check_val("mul_lo", lo, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        check_val("mul_done_pulse", done, 0);
        check_val("mul_hi_hold", hi, 32'hFFFF_FFFF);

        // div -7 / 2
        start_op(C_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bcnt);
        check_val("div_done_cyc", cyc, 33);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        check_val("div_hi", hi, 32'hFFFF_FFFF);

        // div 5 / 0
        start_op(C_DIV, 32'd5, 32'd0);
        wait_done(cyc, bcnt);
        check_val("dz_done_cyc", cyc, 1);
        check_val("dz_busy_cycles", bcnt, 1);
        check_val("dz_lo", lo, 32'hFFFF_FFFF);
        check_val("dz_hi", hi, 32'h0000_0005);

        // INT_MIN / -1
        start_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bcnt);
        check_val("ovf_done_cyc", cyc, 33);
        check_val("ovf_lo", lo, 32'h8000_0000);
        check_val("ovf_hi", hi, 32'h0000_0000);

        // INT_MIN * INT_MIN
        start_op(C_MUL, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, bcnt);
        check_val("minsq_hi", hi, 32'h4000_0000);
        check_val("minsq_lo", lo, 32'h0000_0000);

        // Non-mul/div code is ignored
        start_op(4'b0010, 32'd3, 32'd4);
        seen_b = int'(busy);
        seen_d = int'(done);
        repeat (5) begin
            @(posedge clk);
            #1;
            seen_b += int'(busy);
            seen_d += int'(done);
        end
        check_val("ign_busy", seen_b, 0);
        check_val("ign_done", seen_d, 0);
        check_val("ign_hi", hi, 32'h4000_0000);
        check_val("ign_lo", lo, 32'h0000_0000);

        // div 100 / 7 with a mul request injected at E5
        start_op(C_DIV, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start_op(C_MUL, 32'd2, 32'd2);
        check_val("inj_busy", busy, 1);
        wait_done(cyc, bcnt);
        check_val("inj_done_cyc", cyc, 28);
        check_val("inj_lo", lo, 32'd14);
        check_val("inj_hi", hi, 32'd2);

        // Back-to-back: second start issued in the DONE cycle
        start_op(C_MUL, 32'd3, 32'd4);
        wait_done(cyc, bcnt);
        check_val("b2b1_done_cyc", cyc, 33);
        check_val("b2b1_lo", lo, 32'd12);
        check_val("b2b1_hi", hi, 32'd0);
        start_op(C_MUL, 32'hFFFF_FFFB, 32'd6);
        check_val("b2b2_busy", busy, 1);
        check_val("b2b2_done_low", done, 0);
        wait_done(cyc, bcnt);
        check_val("b2b2_done_cyc", cyc, 33);
        check_val("b2b2_hi", hi, 32'hFFFF_FFFF);
        check_val("b2b2_lo", lo, 32'hFFFF_FFE2);

        // Reset at E10 of a mul
        start_op(C_MUL, 32'd9, 32'd9);
        repeat (9) @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mrst_busy", busy, 0);
        check_val("mrst_hi", hi, 0);
        check_val("mrst_lo", lo, 0);
        #2;
        rst_n  = 1'b1;
        seen_b = 0;
        seen_d = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen_b += int'(busy);
            seen_d += int'(done);
        end
        check_val("mrst_no_busy", seen_b, 0);
        check_val("mrst_no_done", seen_d, 0);
        check_val("mrst_lo_hold", lo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
